dmem_responder: RTL
===================

# dmem_responder

Word-organised data memory that answers load/store requests from the processor datapath. It is the responder end of the datapath's memory request/response handshake and replaces a purely combinational data RAM. Each request is accepted, held for a programmable number of wait states, and then answered. Loads are returned already aligned and sign- or zero-extended per RV32I funct3. Stores write only the addressed byte lanes.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- LATENCY, 1: wait-state cycles between request acceptance and response; range 0 to 15.
- clk  in  1  clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned; the low byte or halfword is used for B or H.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range, or illegal funct3.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid is 1, the request is accepted.
  - Next state is WAIT if LATENCY>0 and RESP if LATENCY=0.
  - The wait counter loads LATENCY-1.
- WAIT: req_ready=0.
  - Counter decrements each cycle.
  - Move to RESP when the counter is 0.
- RESP: rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE. A new request can be accepted in the next cycle.
- Word index is req_addr[log2(DEPTH)+1:2]. Byte offset is req_addr[1:0].
- Error conditions, checked at acceptance:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
  - req_addr ≥ 4·DEPTH.
  - funct3 in {011, 110, 111}.
- Error handling: no array write, rsp_rdata=0, rsp_err=1.
- Store, non-error: committed to the array on the acceptance edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged.
- Stores return rsp_rdata=0 and rsp_err=0.
- Load, non-error: the word is read and the result is extracted and extended on the acceptance edge, then held in the response register.
  - B: byte sign-extended to 32. BU: byte zero-extended.
  - H: halfword sign-extended. HU: halfword zero-extended.
  - W: word as is.
- Array contents are not reset and not initialised; they are X until first written.

## Timing
- Reset values, forced on every rising edge where reset_n=0, from any state:
  - state IDLE, counter 0.
  - req_ready=0 while reset_n=0, 1 in the first cycle after release.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transaction drops the pending response. A store already committed at acceptance remains in the array.
- Acceptance edge to rsp_valid rising: LATENCY+1 cycles. With LATENCY=0, rsp_valid is high in the cycle after acceptance.
- Throughput with rsp_ready held at 1: one request every LATENCY+2 cycles.
- A load issued after a store to the same word sees the stored data, because the store commits at acceptance.
- req_valid and data inputs are ignored outside IDLE. The requester must hold its request until req_ready=1.
- rsp_ready while rsp_valid=0 has no effect.

## Test plan
- Reset: reset_n low 3 cycles with req_valid=1 → no write occurs, rsp_valid=0, req_ready=0; after release, req_ready=1 and rsp_rdata=0.
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_rdata=0xDEADBEEF and rsp_err=0. With LATENCY=1, rsp_valid rises 2 cycles after each acceptance edge.
- Extension on the word 0xDEADBEEF @0x10:
  - LB @0x13 → 0xFFFFFFDE.
  - LBU @0x13 → 0x000000DE.
  - LH @0x12 → 0xFFFFDEAD.
  - LHU @0x10 → 0x0000BEEF.
- Lane writes: SB 0x12345678 @0x11, then LW @0x10 → 0xDEAD78EF. SH 0x0000CAFE @0x12, then LW @0x10 → 0xCAFE78EF.
- Errors:
  - LW @0x12 → rsp_err=1, rsp_rdata=0.
  - SH @0x11 → rsp_err=1; a later LW @0x10 is unchanged.
  - LW @4·DEPTH → rsp_err=1.
  - funct3=011 → rsp_err=1.
- Backpressure and reset:
  - With rsp_ready=0 for 5 cycles, rsp_valid and rsp_rdata stay stable and req_ready=0; a new req_valid is ignored.
  - With LATENCY=0 and rsp_ready=1, back-to-back requests are accepted every 2 cycles.
  - reset_n pulsed low during WAIT → no response is issued, and the responder is in IDLE the cycle after release.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering RV32I load/store
// requests after a fixed number of wait states.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds its request stable until then.
// A response transfers on a rising edge where rsp_valid and rsp_ready are
// both 1; rsp_rdata and rsp_err stay stable while rsp_valid is 1 and
// rsp_ready is 0. Only one request is outstanding at a time.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Wait counter preload; unused when LATENCY is 0 (IDLE goes straight to RESP).
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          illegal;
    logic          misalign;
    logic          out_of_range;
    logic          req_err;
    logic          accept;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign req_ready = reset_n && (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign state_dbg = state;

    // Decode the request: error checks, load extraction and store lane mask.
    always_comb begin
        idx          = req_addr[AW+1:2];
        off          = req_addr[1:0];
        illegal      = 1'b0;
        misalign     = 1'b0;
        out_of_range = ((req_addr >> (AW + 2)) != 32'd0);
        shifted      = mem[idx] >> {off, 3'b000};
        load_data    = 32'd0;
        be           = 4'b0000;
        wd           = req_wdata;
        case (req_funct3)
            3'b000: begin
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                be        = 4'b0001 << off;
                wd        = {4{req_wdata[7:0]}};
            end
            3'b100: begin
                load_data = {24'd0, shifted[7:0]};
            end
            3'b001: begin
                misalign  = off[0];
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                be        = off[1] ? 4'b1100 : 4'b0011;
                wd        = {2{req_wdata[15:0]}};
            end
            3'b101: begin
                misalign  = off[0];
                load_data = {16'd0, shifted[15:0]};
            end
            3'b010: begin
                misalign  = (off != 2'b00);
                load_data = shifted;
                be        = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        req_err = illegal || misalign || out_of_range;
    end

    // Commit non-error stores on the acceptance edge; array is never reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !req_err) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    mem[idx][lane*8 +: 8] <= wd[lane*8 +: 8];
                end
            end
        end
    end

    // Request/wait/response sequencing and the held response register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state   <= (LATENCY == 0) ? S_RESP : S_WAIT;
                        cnt     <= LAT_M1;
                        rdata_q <= (req_err || req_we) ? 32'd0 : load_data;
                        err_q   <= req_err;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
